rr_request_ctrl: RTL and testbench
==================================

// Module: rr_request_ctrl
// PURPOSE
//   Requester-side front end for the round_robin arbiter: N channels queue transaction tokens,
//   drive the arbiter request vector, consume its encoded grant, and stop after a per-channel
//   grant quota. Sits between traffic sources and the arbiter i_request/o_grant pair.
// PARAMETERS
//   REQUEST_WIDTH  8   number of channels N (>=2)
//   PENDING_DEPTH  4   max outstanding tokens per channel (>=1)
//   QUOTA          64  grants per channel before it retires; 0 = unlimited
//   COUNT_WIDTH    16  width of statistics counters
// PORTS
//   clk             in   1                clock
//   rst_n           in   1                reset, asynchronous, active-low
//   i_clear         in   1                sync clear of quota/stat counters (pending kept)
//   i_push          in   N                per-channel token push
//   o_push_ready    out  N                channel can accept a push
//   o_request       out  N                to arbiter i_request
//   i_grant         in   $clog2(N)        from arbiter o_grant (encoded index)
//   o_pop           out  N                one-hot: grant consumed this cycle
//   o_quota_done    out  N                channel retired (quota reached)
//   o_all_done      out  1                all channels retired
//   o_grant_count   out  N*COUNT_WIDTH    per-channel grants (stats; see CONFIGURATION)
//   o_busy_cycles   out  COUNT_WIDTH      cycles with any request asserted (stats)
// BEHAVIOUR
//   - Reset: pending=0, grant counts=0, all channels IDLE; o_request, o_pop, o_quota_done,
//     o_all_done, stats all 0; o_push_ready all 1.
//   - Per-channel FSM: IDLE (pending==0) -> REQ (pending>0); REQ -> IDLE when last token popped;
//     IDLE/REQ -> DONE when grant count reaches QUOTA (QUOTA!=0); DONE -> IDLE/REQ on i_clear.
//   - o_request[i] = state==REQ; decoded from registers only (no comb path from inputs).
//   - Grant accept: o_pop[i] = o_request[i] && (i_grant==i), combinational, same cycle.
//     i_grant >= N or pointing at a non-requesting channel: no pop, no state change.
//   - o_push_ready[i] = pending[i] != PENDING_DEPTH (no pass-through on same-cycle pop).
//   - Push accepted when i_push[i] && o_push_ready[i]; ignored otherwise (no error).
//   - Next pending = pending + push_acc - pop; push+pop same cycle -> unchanged.
//   - Pop of last token: o_request[i] drops the following cycle (1-cycle latency).
//   - Grant count increments on pop, saturates at QUOTA; on reaching QUOTA channel enters DONE
//     next cycle, request masked, pending retained, pushes still accepted up to depth.
//   - o_all_done = &o_quota_done; constant 0 when QUOTA==0.
//   - i_clear: counts -> 0 next edge; clear beats same-cycle pop increment; DONE channels
//     leave DONE and resume requesting if pending>0.
//   - Reset mid-operation: all pending tokens discarded, immediate (async) return to reset values.
// CONFIGURATION
//   RR_REQ_STATS_EN defined: o_grant_count[i] counts pops, o_busy_cycles counts cycles with
//   |o_request; both saturate at 2**COUNT_WIDTH-1, cleared by reset and i_clear.
//   Not defined: counters not built; both ports tied to '0 (port list unchanged).
// STRUCTURE
//   rr_request_pkg: channel state enum {IDLE, REQ, DONE}, width helper functions for
//   pending/quota counters.
//   Sub-module rr_request_channel: one channel's FSM, pending counter, quota counter;
//   instantiated N times by generate. Top holds grant decode, all_done, optional stats.
// TESTING
//   1 push ch3 once, i_grant=3 held -> o_request[3] 1 cycle after push, o_pop[3] 1 cycle,
//     o_request[3] low next cycle, state IDLE.
//   2 push ch0 5x with depth 4, no grant -> o_push_ready[0]=0 after 4th, 5th push dropped,
//     then 4 grants -> exactly 4 pops.
//   3 pending=2 on ch5, push and grant same cycle -> pending stays 2, o_request[5] stays 1.
//   4 QUOTA=64, all 8 channels kept full under round_robin -> each sees 64 pops,
//     o_quota_done all 1, o_all_done 1, no further o_request; i_clear -> requests resume.
//   5 i_grant=2 while request[2]=0, and i_grant=7 with N=6 -> no o_pop, no count change.
//   6 RR_REQ_STATS_EN: 10 grants on ch1 -> o_grant_count[1]=10; reset mid-run -> all outputs
//     to reset values asynchronously; without macro both stat ports read 0.

Source files
------------

// File: rtl/rr_request_pkg.sv
// rr_request_pkg
//   Shared definitions for the round-robin requester front end.
//   - ch_state_t    : per-channel state (IDLE, REQ, DONE)
//   - pending_width : bits needed to hold a pending count 0..depth
//   - quota_width   : bits needed to hold a grant count 0..quota
package rr_request_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    function automatic int pending_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // An unlimited quota (0) still gets a 1-bit counter so the channel
    // port map stays uniform; it simply never advances.
    function automatic int quota_width(input int quota);
        return (quota == 0) ? 1 : $clog2(quota + 1);
    endfunction

endpackage

// File: rtl/rr_request_channel.sv
// rr_request_channel
//   One requester channel: pending-token counter, grant quota counter and the
//   IDLE/REQ/DONE state machine. The request output is decoded from the state
//   register only.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clear        synchronous clear of the quota counter (pending kept)
//   i_push         token push from the traffic source
//   i_grant_hit    arbiter grant index equals this channel
//   o_push_ready   pending count below depth
//   o_request      channel is in REQ
//   o_done         channel is in DONE (quota reached)
module rr_request_channel
    import rr_request_pkg::*;
#(
    parameter int PENDING_DEPTH = 4,
    parameter int QUOTA         = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_push,
    input  logic i_grant_hit,
    output logic o_push_ready,
    output logic o_request,
    output logic o_done
);

    localparam int PW = pending_width(PENDING_DEPTH);
    localparam int QW = quota_width(QUOTA);
    localparam logic [PW-1:0] DEPTH_V = PW'(PENDING_DEPTH);
    localparam logic [QW-1:0] QUOTA_V = QW'(QUOTA);

    ch_state_t     state, state_next;
    logic [PW-1:0] pending, pending_next;
    logic [QW-1:0] quota_cnt, quota_cnt_next;
    logic          push_acc;
    logic          pop;

    assign o_request    = (state == REQ);
    assign o_done       = (state == DONE);
    assign o_push_ready = (pending != DEPTH_V);
    assign push_acc     = i_push && o_push_ready;
    // A grant only counts while requesting, so DONE/IDLE channels ignore it.
    assign pop          = i_grant_hit && (state == REQ);

    // Pending count: push and pop in the same cycle cancel out.
    always_comb begin
        pending_next = pending;
        if (push_acc && !pop) begin
            pending_next = pending + PW'(1);
        end else if (pop && !push_acc) begin
            pending_next = pending - PW'(1);
        end
    end

    // Grant quota counter: clear wins over a same-cycle pop; saturates at QUOTA.
    always_comb begin
        quota_cnt_next = quota_cnt;
        if (i_clear) begin
            quota_cnt_next = '0;
        end else if ((QUOTA != 0) && pop && (quota_cnt != QUOTA_V)) begin
            quota_cnt_next = quota_cnt + QW'(1);
        end
    end

    // State follows the next pending count so the request rises one cycle
    // after the first push and falls one cycle after the last pop.
    always_comb begin
        state_next = state;
        if (i_clear) begin
            state_next = (pending_next != '0) ? REQ : IDLE;
        end else if ((QUOTA != 0) && (quota_cnt_next == QUOTA_V)) begin
            state_next = DONE;
        end else if (state != DONE) begin
            state_next = (pending_next != '0) ? REQ : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            quota_cnt <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            quota_cnt <= quota_cnt_next;
        end
    end

endmodule

// File: rtl/rr_request_ctrl.sv
// rr_request_ctrl
//   Requester-side front end for a round-robin arbiter. N channels queue
//   tokens, raise requests, consume the encoded grant and retire after a
//   per-channel grant quota (QUOTA = 0 means unlimited).
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_clear          sync clear of quota and statistics counters
//   i_push[N]        per-channel token push;  o_push_ready[N] push accepted
//   o_request[N]     to arbiter request vector
//   i_grant          encoded grant index from the arbiter
//   o_pop[N]         one-hot, grant consumed this cycle (combinational)
//   o_quota_done[N]  channel retired;  o_all_done  every channel retired
//   o_grant_count    per-channel pop counters, COUNT_WIDTH each
//   o_busy_cycles    cycles with any request asserted
// Configuration
//   RR_REQ_STATS_EN  builds the statistics counters; otherwise both
//                    statistics ports are tied to zero.
module rr_request_ctrl
    import rr_request_pkg::*;
#(
    parameter int REQUEST_WIDTH = 8,
    parameter int PENDING_DEPTH = 4,
    parameter int QUOTA         = 64,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_clear,
    input  logic [REQUEST_WIDTH-1:0]           i_push,
    output logic [REQUEST_WIDTH-1:0]           o_push_ready,
    output logic [REQUEST_WIDTH-1:0]           o_request,
    input  logic [$clog2(REQUEST_WIDTH)-1:0]   i_grant,
    output logic [REQUEST_WIDTH-1:0]           o_pop,
    output logic [REQUEST_WIDTH-1:0]           o_quota_done,
    output logic                               o_all_done,
    output logic [REQUEST_WIDTH*COUNT_WIDTH-1:0] o_grant_count,
    output logic [COUNT_WIDTH-1:0]             o_busy_cycles
);

    localparam int GW = $clog2(REQUEST_WIDTH);

    logic [REQUEST_WIDTH-1:0] grant_hit;

    // An index >= N matches no channel, so out-of-range grants are ignored.
    for (genvar i = 0; i < REQUEST_WIDTH; i++) begin : g_ch
        assign grant_hit[i] = (i_grant == GW'(i));

        rr_request_channel #(
            .PENDING_DEPTH (PENDING_DEPTH),
            .QUOTA         (QUOTA)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_clear      (i_clear),
            .i_push       (i_push[i]),
            .i_grant_hit  (grant_hit[i]),
            .o_push_ready (o_push_ready[i]),
            .o_request    (o_request[i]),
            .o_done       (o_quota_done[i])
        );
    end

    assign o_pop      = o_request & grant_hit;
    assign o_all_done = (QUOTA != 0) && (&o_quota_done);

`ifdef RR_REQ_STATS_EN
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [COUNT_WIDTH-1:0] busy_cnt;

    // Per-channel pop counters, saturating; clear wins over a same-cycle pop.
    for (genvar i = 0; i < REQUEST_WIDTH; i++) begin : g_stat
        logic [COUNT_WIDTH-1:0] grant_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grant_cnt <= '0;
            end else if (i_clear) begin
                grant_cnt <= '0;
            end else if (o_pop[i] && (grant_cnt != CNT_MAX)) begin
                grant_cnt <= grant_cnt + COUNT_WIDTH'(1);
            end
        end

        assign o_grant_count[i*COUNT_WIDTH +: COUNT_WIDTH] = grant_cnt;
    end

    // Busy cycle counter, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (i_clear) begin
            busy_cnt <= '0;
        end else if ((|o_request) && (busy_cnt != CNT_MAX)) begin
            busy_cnt <= busy_cnt + COUNT_WIDTH'(1);
        end
    end

    assign o_busy_cycles = busy_cnt;
`else
    assign o_grant_count = '0;
    assign o_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_rr_request_ctrl.sv
// tb_rr_request_ctrl
//   Self-checking bench for rr_request_ctrl. A main instance (N=8, depth 4,
//   quota 64) is followed cycle by cycle by a reference model whose expected
//   outputs are queued when stimulus is driven and compared after the clock
//   edge. A second instance (N=6, depth 2, unlimited quota) covers
//   out-of-range grant indices.
module tb_rr_request_ctrl;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int QUOTA = 64;
    localparam int CW    = 16;
    localparam int GW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic [N-1:0]    request;
        logic [N-1:0]    push_ready;
        logic [N-1:0]    quota_done;
        logic            all_done;
        logic [N*CW-1:0] grant_count;
        logic [CW-1:0]   busy;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic [N-1:0]    push;
    logic [N-1:0]    push_ready;
    logic [N-1:0]    request;
    logic [GW-1:0]   grant;
    logic [N-1:0]    pop;
    logic [N-1:0]    quota_done;
    logic            all_done;
    logic [N*CW-1:0] grant_count;
    logic [CW-1:0]   busy;

    logic [5:0]      push6;
    logic [5:0]      push_ready6;
    logic [5:0]      request6;
    logic [2:0]      grant6;
    logic [5:0]      pop6;
    logic [5:0]      quota_done6;
    logic            all_done6;
    logic [47:0]     grant_count6;
    logic [7:0]      busy6;

    int   n_compared;
    int   n_mismatched;
    exp_t sb_q[$];

    int m_pend[N];
    int m_cnt[N];
    int m_gc[N];
    int m_state[N];
    int m_busy;

    rr_request_ctrl #(
        .REQUEST_WIDTH (N),
        .PENDING_DEPTH (DEPTH),
        .QUOTA         (QUOTA),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (clear),
        .i_push        (push),
        .o_push_ready  (push_ready),
        .o_request     (request),
        .i_grant       (grant),
        .o_pop         (pop),
        .o_quota_done  (quota_done),
        .o_all_done    (all_done),
        .o_grant_count (grant_count),
        .o_busy_cycles (busy)
    );

    rr_request_ctrl #(
        .REQUEST_WIDTH (6),
        .PENDING_DEPTH (2),
        .QUOTA         (0),
        .COUNT_WIDTH   (8)
    ) dut6 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (1'b0),
        .i_push        (push6),
        .o_push_ready  (push_ready6),
        .o_request     (request6),
        .i_grant       (grant6),
        .o_pop         (pop6),
        .o_quota_done  (quota_done6),
        .o_all_done    (all_done6),
        .o_grant_count (grant_count6),
        .o_busy_cycles (busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_pend[i]  = 0;
            m_cnt[i]   = 0;
            m_gc[i]    = 0;
            m_state[i] = 0;
        end
        m_busy = 0;
        sb_q.delete();
    endtask

    // Reset values of the main instance, checked without waiting for a clock.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_request"},     request,     '0);
        checkOutput({tag, "_push_ready"},  push_ready,  {N{1'b1}});
        checkOutput({tag, "_pop"},         pop,         '0);
        checkOutput({tag, "_quota_done"},  quota_done,  '0);
        checkOutput({tag, "_all_done"},    all_done,    1'b0);
        checkOutput({tag, "_grant_count"}, grant_count, '0);
        checkOutput({tag, "_busy"},        busy,        '0);
    endtask

    // Drive one cycle of stimulus (called at a falling edge), check the
    // combinational pop, advance the model, queue its expectation and compare
    // it with the registered outputs after the next rising edge.
    task automatic applyStimulus(input logic [N-1:0] p, input int g, input logic c);
        logic [N-1:0] exp_pop;
        logic         any_req;
        int           pa;
        exp_t         e;
        exp_t         got;
        push  = p;
        grant = g[GW-1:0];
        clear = c;
        #1;
        any_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_pop[i] = (m_state[i] == 1) && (g == i);
            if (m_state[i] == 1) any_req = 1'b1;
        end
        checkOutput("pop", pop, exp_pop);

        for (int i = 0; i < N; i++) begin
            pa = (p[i] && (m_pend[i] != DEPTH)) ? 1 : 0;
            m_pend[i] = m_pend[i] + pa - (exp_pop[i] ? 1 : 0);
            if (c) begin
                m_cnt[i]   = 0;
                m_gc[i]    = 0;
                m_state[i] = (m_pend[i] > 0) ? 1 : 0;
            end else begin
                if (exp_pop[i] && (m_cnt[i] < QUOTA)) m_cnt[i]++;
                if (exp_pop[i] && (m_gc[i] < CMAX)) m_gc[i]++;
                if ((QUOTA != 0) && (m_cnt[i] == QUOTA)) m_state[i] = 2;
                else if (m_state[i] != 2) m_state[i] = (m_pend[i] > 0) ? 1 : 0;
            end
        end
        if (c) m_busy = 0;
        else if (any_req && (m_busy < CMAX)) m_busy++;

        e.all_done = 1'b1;
        for (int i = 0; i < N; i++) begin
            e.request[i]    = (m_state[i] == 1);
            e.push_ready[i] = (m_pend[i] != DEPTH);
            e.quota_done[i] = (m_state[i] == 2);
            if (m_state[i] != 2) e.all_done = 1'b0;
`ifdef RR_REQ_STATS_EN
            e.grant_count[i*CW +: CW] = CW'(m_gc[i]);
`else
            e.grant_count[i*CW +: CW] = '0;
`endif
        end
        if (QUOTA == 0) e.all_done = 1'b0;
`ifdef RR_REQ_STATS_EN
        e.busy = CW'(m_busy);
`else
        e.busy = '0;
`endif
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checkOutput("request",     request,     got.request);
        checkOutput("push_ready",  push_ready,  got.push_ready);
        checkOutput("quota_done",  quota_done,  got.quota_done);
        checkOutput("all_done",    all_done,    got.all_done);
        checkOutput("grant_count", grant_count, got.grant_count);
        checkOutput("busy",        busy,        got.busy);
        @(negedge clk);
    endtask

    function automatic bit modelAllDone();
        for (int i = 0; i < N; i++) begin
            if (m_state[i] != 2) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        int  ptr;
        int  g;
        int  cycles;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        push  = '0;
        grant = '0;
        push6  = '0;
        grant6 = '0;
        modelReset();
        #3;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Second instance: out-of-range and non-requesting grants are ignored.
        push6  = 6'b100000;
        grant6 = 3'd7;
        @(posedge clk); #1;
        checkOutput("n6_request", request6, 6'b100000);
        @(negedge clk);
        push6 = '0;
        #1;
        checkOutput("n6_pop_g7", pop6, '0);
        grant6 = 3'd6;
        #1;
        checkOutput("n6_pop_g6", pop6, '0);
        @(posedge clk); #1;
        checkOutput("n6_request_held", request6, 6'b100000);
        @(negedge clk);
        grant6 = 3'd2;
        #1;
        checkOutput("n6_pop_g2", pop6, '0);
        grant6 = 3'd5;
        #1;
        checkOutput("n6_pop_g5", pop6, 6'b100000);
        @(posedge clk); #1;
        checkOutput("n6_request_drop", request6, '0);
        checkOutput("n6_all_done", all_done6, 1'b0);
        checkOutput("n6_push_ready", push_ready6, 6'b111111);
        @(negedge clk);
        grant6 = '0;

        // Single token on ch3 with grant held on 3.
        applyStimulus(8'h08, 3, 1'b0);
        applyStimulus(8'h00, 3, 1'b0);
        applyStimulus(8'h00, 3, 1'b0);

        // Overfill ch0, then drain with exactly four pops.
        for (int k = 0; k < 5; k++) applyStimulus(8'h01, 6, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(8'h00, 0, 1'b0);

        // ch5 with two pending, push and pop together, then drain.
        applyStimulus(8'h20, 6, 1'b0);
        applyStimulus(8'h20, 6, 1'b0);
        applyStimulus(8'h20, 5, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(8'h00, 5, 1'b0);

        // Grant pointing at an idle channel, including while others request.
        applyStimulus(8'h00, 2, 1'b0);
        applyStimulus(8'h04, 4, 1'b0);
        applyStimulus(8'h00, 4, 1'b0);
        applyStimulus(8'h00, 2, 1'b0);

        // Ten grants on ch1.
        for (int k = 0; k < 11; k++) applyStimulus(8'h02, 1, 1'b0);
`ifdef RR_REQ_STATS_EN
        checkOutput("gc1_ten", grant_count[CW +: CW], 16'd10);
`else
        checkOutput("gc1_off", grant_count[CW +: CW], 16'd0);
`endif

        // Asynchronous reset in the middle of a cycle with ch1 still pending.
        applyStimulus(8'h01, 6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill all channels and arbitrate round-robin until every quota is met.
        ptr    = N - 1;
        cycles = 0;
        while (!modelAllDone() && (cycles < 900)) begin
            g = 0;
            for (int k = 1; k <= N; k++) begin
                if (m_state[(ptr + k) % N] == 1) begin
                    g = (ptr + k) % N;
                    ptr = g;
                    break;
                end
            end
            applyStimulus({N{1'b1}}, g, 1'b0);
            cycles++;
        end
        checkOutput("quota_within_budget", modelAllDone(), 1'b1);
        checkOutput("all_done_final", all_done, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus({N{1'b1}}, k, 1'b0);

        // Clear restarts requests; clear beats a same-cycle pop.
        applyStimulus(8'h00, 0, 1'b1);
        applyStimulus(8'h00, 0, 1'b0);
        applyStimulus(8'h00, 1, 1'b1);
        applyStimulus(8'h00, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
